// File: rtl/main_control_fsm.sv
// Multicycle RISC-V main control unit: a Moore FSM that sequences fetch,
// decode, memory, ALU and branch steps and counts retired instructions.
module main_control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        memReady,
  output logic        pcWrite,
  output logic        irWrite,
  output logic        memWrite,
  output logic        regWrite,
  output logic        adrSrc,
  output logic [1:0]  aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [1:0]  aluOp,
  output logic [1:0]  resultSrc,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    BEQ      = 4'd8,
    ILLEGAL  = 4'd9
  } stateT;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  stateT       state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic        illegal_q, illegal_d;

  logic pcWriteRaw, irWriteRaw, memWriteRaw, regWriteRaw;
  logic retire;

  // State, retired-instruction counter and sticky illegal flag; reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      instret_q <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and Moore outputs per state; everything not named for a state stays 0
  always_comb begin
    state_d     = state_q;
    pcWriteRaw  = 1'b0;
    irWriteRaw  = 1'b0;
    memWriteRaw = 1'b0;
    regWriteRaw = 1'b0;
    adrSrc      = 1'b0;
    aluSrcA     = 2'b00;
    aluSrcB     = 2'b00;
    aluOp       = 2'b00;
    resultSrc   = 2'b00;
    retire      = 1'b0;

    case (state_q)
      FETCH: begin
        aluSrcB    = 2'b10;
        resultSrc  = 2'b10;
        pcWriteRaw = memReady;
        irWriteRaw = memReady;
        if (memReady) state_d = DECODE;
      end
      DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = EXECUTER;
          OP_BEQ:       state_d = BEQ;
          default:      state_d = ILLEGAL;
        endcase
      end
      MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        state_d = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adrSrc = 1'b1;
        if (memReady) state_d = MEMWB;
      end
      MEMWB: begin
        resultSrc   = 2'b01;
        regWriteRaw = 1'b1;
        state_d     = FETCH;
        retire      = 1'b1;
      end
      MEMWRITE: begin
        adrSrc      = 1'b1;
        memWriteRaw = 1'b1;
        if (memReady) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      EXECUTER: begin
        aluSrcA = 2'b10;
        aluOp   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        regWriteRaw = 1'b1;
        state_d     = FETCH;
        retire      = 1'b1;
      end
      BEQ: begin
        aluSrcA    = 2'b10;
        aluOp      = 2'b01;
        pcWriteRaw = zero;
        state_d    = FETCH;
        retire     = 1'b1;
      end
      ILLEGAL: begin
        state_d = ILLEGAL;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    instret_d = retire ? (instret_q + 32'd1) : instret_q;
    illegal_d = illegal_q | (state_d == ILLEGAL);
  end

  // Write enables are gated by reset so no architectural write happens during a reset cycle
  always_comb begin
    pcWrite  = pcWriteRaw  & ~reset;
    irWrite  = irWriteRaw  & ~reset;
    memWrite = memWriteRaw & ~reset;
    regWrite = regWriteRaw & ~reset;
  end

  assign illegal = illegal_q;
  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: doc/main_control_fsm.md
MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The ports SHALL be as follows (name  direction  width  meaning):
  - clk  in  1  clock; all state updates on the rising edge.
  - reset  in  1  synchronous, active-high.
  - opcode  in  7  instruction opcode from the instruction register; sampled in DECODE.
  - zero  in  1  ALU zero flag; used in BEQ.
  - memReady  in  1  memory access completes this cycle.
  - pcWrite  out  1  PC write enable.
  - irWrite  out  1  instruction register write enable.
  - memWrite  out  1  data memory write enable.
  - regWrite  out  1  register file write enable.
  - adrSrc  out  1  memory address select: 0 = PC, 1 = result.
  - aluSrcA  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1.
  - aluSrcB  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
  - aluOp  out  2  to the ALU control stage: 00 = add, 01 = sub (branch), 10 = decode by fun3/fun7.
  - resultSrc  out  2  result select: 00 = aluOut register, 01 = memory data, 10 = ALU result.
  - illegal  out  1  sticky flag: unsupported opcode seen.
  - state  out  4  current state encoding, for debug.
  - instret  out  32  retired instruction count.

Function
REQ-003 The block SHALL be a Moore FSM with these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, BEQ=8, ILLEGAL=9.
REQ-004 Any output not listed for a state SHALL be 0.
REQ-005 FETCH: adrSrc=0, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10; irWrite and pcWrite equal memReady; stay in FETCH while memReady=0, otherwise go to DECODE.
REQ-006 DECODE: aluSrcA=01, aluSrcB=01, aluOp=00. Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 1100011 -> BEQ; any other value -> ILLEGAL.
REQ-007 MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00. Next state is MEMREAD if opcode=0000011, else MEMWRITE.
REQ-008 MEMREAD: adrSrc=1, resultSrc=00; wait while memReady=0, then go to MEMWB.
REQ-009 MEMWB: resultSrc=01, regWrite=1 for exactly one cycle; then go to FETCH.
REQ-010 MEMWRITE: adrSrc=1, resultSrc=00, memWrite=1, held for the whole wait; go to FETCH on memReady=1.
REQ-011 EXECUTER: aluSrcA=10, aluSrcB=00, aluOp=10; then go to ALUWB.
REQ-012 ALUWB: resultSrc=00, regWrite=1; then go to FETCH.
REQ-013 BEQ: aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00; pcWrite=zero, combinational in this state; then go to FETCH.
REQ-014 ILLEGAL: illegal SHALL be set and SHALL remain set; the FSM stays in ILLEGAL until reset; all write enables are 0.
REQ-015 instret SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ; it wraps 0xFFFFFFFF -> 0.
REQ-016 Latency with memReady=1: R-type = 4 cycles, lw = 5, sw = 4, beq = 3.
REQ-017 pcWrite, irWrite, memWrite and regWrite SHALL be forced to 0 in any cycle where reset=1, whatever the state.

Reset
REQ-018 At the first rising edge with reset=1: state=FETCH, instret=0, illegal=0.
REQ-019 Reset SHALL override every pending transition, including memory waits and ILLEGAL.
REQ-020 There SHALL be no partial-instruction retirement on reset.
REQ-021 After reset deasserts, the first cycle SHALL present FETCH outputs: pcWrite = irWrite = memReady.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  - R-type: opcode=0110011, memReady=1 -> state 0,1,6,7,0; aluOp=10 in state 6; regWrite high 1 cycle; instret 0 -> 1.
  - lw with wait: opcode=0000011, memReady=0 for 2 cycles in MEMREAD -> state 0,1,2,3,3,3,4,0 (7 cycles); regWrite with resultSrc=01 in state 4.
  - beq: opcode=1100011, zero=1 -> pcWrite=1 in BEQ, aluOp=01. Repeat with zero=0 -> pcWrite=0. Both runs increment instret.
  - Illegal: opcode=1111111 -> DECODE then ILLEGAL; illegal=1 for 10+ cycles, instret unchanged, no write enables; then reset -> FETCH, illegal=0.
  - Reset mid-store: reset=1 in MEMWRITE with memReady=0 -> memWrite=0 in that cycle, state=0 next, instret unchanged.
  - Fetch stall: memReady=0 for 3 cycles in FETCH -> irWrite = pcWrite = 0 throughout; both pulse 1 on the cycle memReady=1.
